pdm_receiver: RTL and testbench

Consumer side of the PDM microphone link. Samples the microphone's 1-bit `M_DATA` stream on rising edges of the `M_CLK` generated by the mic clock divider, with `M_LRSEL` tied low. Counts ones over a fixed decimation window and delivers one PCM sample per window through a valid/ready register. Sits between the mic pins and the downstream amplitude/spectrum logic.

---
 rtl/pdm_pkg.sv | 13 +
 rtl/pdm_sync_edge.sv | 39 +++
 rtl/pdm_receiver.sv | 129 ++++++++++++
 tb/tb_pdm_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and defaults for the PDM microphone receiver.
// Optional build macro used by pdm_receiver: PDM_RX_SIGNED_EN.
package pdm_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } pdm_state_t;

  localparam int PDM_DECIM_DEFAULT  = 128;
  localparam int PDM_WARMUP_DEFAULT = 2;

endpackage

// File: rtl/pdm_sync_edge.sv
// pdm_sync_edge: 2-FF synchroniser for the mic data pin and
// rising-edge detect of the already-registered mic clock.
module pdm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mclk_i,
  input  logic mdata_i,
  output logic data_s_o,
  output logic rise_o
);

  logic data_s1_q, data_s1_d;
  logic data_s2_q, data_s2_d;
  logic mclk_d_q, mclk_d_d;

  // next state of the synchroniser chain and clock history
  always_comb begin
    data_s1_d = mdata_i;
    data_s2_d = data_s1_q;
    mclk_d_d  = mclk_i;
  end

  // synchroniser and edge-detect registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_s1_q <= 1'b0;
      data_s2_q <= 1'b0;
      mclk_d_q  <= 1'b0;
    end else begin
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      mclk_d_q  <= mclk_d_d;
    end
  end

  assign data_s_o = data_s2_q;
  assign rise_o   = mclk_i & ~mclk_d_q;

endmodule

// File: rtl/pdm_receiver.sv
// pdm_receiver: counts PDM ones per decimation window and presents one
// PCM sample per window. Build macro PDM_RX_SIGNED_EN selects signed output.
module pdm_receiver
  import pdm_pkg::*;
#(
  parameter int DECIM          = PDM_DECIM_DEFAULT,
  parameter int WARMUP_WINDOWS = PDM_WARMUP_DEFAULT,
  parameter int SAMPLE_W       = $clog2(DECIM) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                M_CLK,
  input  logic                M_DATA,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                overrun_o
);

  localparam int BW = $clog2(DECIM);
  localparam int WW = (WARMUP_WINDOWS > 1) ? $clog2(WARMUP_WINDOWS) : 1;
  localparam int WLAST_I = (WARMUP_WINDOWS == 0) ? 0 : WARMUP_WINDOWS - 1;
  localparam logic [WW-1:0] WLAST = WW'(WLAST_I);
  localparam pdm_state_t RST_STATE = (WARMUP_WINDOWS == 0) ? RUN : WARMUP;

  logic data_s;
  logic rise;

  pdm_sync_edge u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .mclk_i   (M_CLK),
    .mdata_i  (M_DATA),
    .data_s_o (data_s),
    .rise_o   (rise)
  );

  pdm_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0] ones_q, ones_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic [SAMPLE_W-1:0] total;
  logic [SAMPLE_W-1:0] mapped;
  logic                win_end;
  logic                load;

  // window accounting, warm-up FSM and output handshake
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    bitcnt_d = bitcnt_q;
    wcnt_d   = wcnt_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    total   = ones_q + SAMPLE_W'(data_s);
    win_end = rise & (&bitcnt_q);
    load    = 1'b0;
`ifdef PDM_RX_SIGNED_EN
    mapped = total - SAMPLE_W'(DECIM / 2);
`else
    mapped = total;
`endif

    if (rise) begin
      bitcnt_d = bitcnt_q + BW'(1);
      ones_d   = win_end ? '0 : total;
    end

    case (state_q)
      WARMUP: begin
        if (win_end) begin
          if (wcnt_q == WLAST) begin
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      RUN: begin
        load = win_end;
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    if (load) begin
      sample_d = mapped;
      valid_d  = 1'b1;
      if (valid_q & ~sample_ready_i) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q & sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // state, counters and output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RST_STATE;
      ones_q   <= '0;
      bitcnt_q <= '0;
      wcnt_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      bitcnt_q <= bitcnt_d;
      wcnt_q   <= wcnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_pdm_receiver.sv
// tb_pdm_receiver: randomized PDM stimulus against a window-level
// reference model of the receiver.
module tb_pdm_receiver;

  localparam int DECIM = 128;
  localparam int WARM  = 2;
  localparam int FDIV  = 32;
  localparam int SW    = 8;
  localparam int LIM   = 30000;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          M_CLK = 1'b0;
  logic          M_DATA = 1'b0;
  logic [SW-1:0] sample_o;
  logic          sample_valid_o;
  logic          sample_ready_i = 1'b1;
  logic          overrun_o;

  pdm_receiver dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .M_CLK          (M_CLK),
    .M_DATA         (M_DATA),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // stimulus state
  int div = 0;
  int mode = 0;
  int dens = 50;
  bit alt = 1'b0;

  // reference model state
  bit m_prev = 0, p1 = 0, p2 = 0;
  int rises = 0, acc = 0;
  bit e_valid = 0, e_ovr = 0;
  int e_sample = 0;
  int nloads = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int map(input int t);
`ifdef PDM_RX_SIGNED_EN
    return t - DECIM / 2;
`else
    return t;
`endif
  endfunction

  function automatic int obs_sample();
`ifdef PDM_RX_SIGNED_EN
    return int'($signed(sample_o));
`else
    return int'(sample_o);
`endif
  endfunction

  function automatic bit next_bit();
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin alt = ~alt; return alt; end
      default: return ($urandom_range(0, 99) < dens);
    endcase
  endfunction

  // one clock edge of the reference: pin is counted 2 cycles late,
  // one sample per DECIM rises once WARM windows have passed
  task automatic model_edge();
    bit rise;
    bit ld;
    int val;
    ld = 0;
    val = 0;
    if (rst_i) begin
      m_prev = 0; p1 = 0; p2 = 0;
      rises = 0; acc = 0;
      e_valid = 0; e_ovr = 0; e_sample = 0;
    end else begin
      rise = M_CLK && !m_prev;
      if (rise) begin
        acc += int'(p2);
        rises++;
        if (rises % DECIM == 0) begin
          if (rises / DECIM > WARM) begin
            ld = 1;
            val = map(acc);
          end
          acc = 0;
        end
      end
      if (ld) begin
        if (e_valid && !sample_ready_i) e_ovr = 1;
        e_valid = 1;
        e_sample = val;
        nloads++;
      end else if (e_valid && sample_ready_i) begin
        e_valid = 0;
      end
      p2 = p1;
      p1 = M_DATA;
      m_prev = M_CLK;
    end
  endtask

  task automatic step();
    M_CLK = (div >= FDIV / 2);
    if (div == 0) M_DATA = next_bit();
    @(posedge clk_i);
    model_edge();
    div = (div + 1) % FDIV;
    #1;
    chk("valid", int'(sample_valid_o), int'(e_valid));
    chk("overrun", int'(overrun_o), int'(e_ovr));
    if (e_valid) chk("sample", obs_sample(), e_sample);
  endtask

  task automatic wait_loads(input int n, input string tag);
    int target;
    target = nloads + n;
    for (int i = 0; i < LIM && nloads < target; i++) step();
    chk(tag, int'(nloads >= target), 1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < LIM && sample_valid_o !== 1'b1; i++) step();
    chk(tag, int'(sample_valid_o === 1'b1), 1);
  endtask

  initial begin
    int exp_hi, exp_lo, exp_mid;
    bit found;
`ifdef PDM_RX_SIGNED_EN
    exp_hi = 64; exp_lo = -64; exp_mid = 0;
`else
    exp_hi = 128; exp_lo = 0; exp_mid = 64;
`endif

    mode = 1;
    rst_i = 1'b1;
    repeat (4) step();
    chk("reset_sample", obs_sample(), 0);
    chk("reset_valid", int'(sample_valid_o), 0);
    chk("reset_ovr", int'(overrun_o), 0);
    rst_i = 1'b0;

    // constant ones: first sample right after rise 384
    wait_valid("const1_timeout");
    chk("const1_first_rise", rises, (WARM + 1) * DECIM);
    chk("const1_first", obs_sample(), exp_hi);
    wait_loads(1, "const1_timeout2");
    chk("const1_next", obs_sample(), exp_hi);

    mode = 0;
    step();
    wait_loads(1, "const0_timeout");
    chk("const0", obs_sample(), exp_lo);

    mode = 2;
    step();
    wait_loads(1, "alt_timeout");
    chk("alt", obs_sample(), exp_mid);

    mode = 3;
    dens = $urandom_range(10, 90);
    step();
    wait_loads(1, "rand_timeout");

    // same-cycle load and transfer
    step();
    sample_ready_i = 1'b0;
    wait_loads(1, "same_timeout1");
    chk("same_pre_ovr", int'(overrun_o), 0);
    found = 0;
    for (int i = 0; i < LIM && !found; i++) begin
      if (div == FDIV / 2 && rises % DECIM == DECIM - 1) found = 1;
      else step();
    end
    chk("same_timeout2", int'(found), 1);
    sample_ready_i = 1'b1;
    step();
    chk("same_valid", int'(sample_valid_o), 1);
    chk("same_ovr", int'(overrun_o), 0);
    step();
    chk("same_drop", int'(sample_valid_o), 0);

    // backpressure across two window ends
    dens = $urandom_range(0, 100);
    sample_ready_i = 1'b0;
    wait_loads(2, "bp_timeout");
    chk("bp_ovr", int'(overrun_o), 1);
    chk("bp_sample", obs_sample(), e_sample);
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
    chk("bp_drop", int'(sample_valid_o), 0);
    chk("bp_sticky", int'(overrun_o), 1);
    step();
    sample_ready_i = 1'b1;

    // reset at bit 70 of a run window
    found = 0;
    for (int i = 0; i < LIM && !found; i++) begin
      step();
      if (rises > (WARM + 1) * DECIM && rises % DECIM == 70) found = 1;
    end
    chk("rst_timeout", int'(found), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_mid_sample", obs_sample(), 0);
    chk("rst_mid_valid", int'(sample_valid_o), 0);
    chk("rst_mid_ovr", int'(overrun_o), 0);
    wait_valid("rst_valid_timeout");
    chk("rst_first_rise", rises, (WARM + 1) * DECIM);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
